// File: rtl/fft_mag_buffer.sv
// fft_mag_buffer: squares each FFT output bin and buffers one frame of magnitudes for the M3.
// Defining FFT_HALF_SPECTRUM_EN stores only bins 0..POINTS/2-1 (the rest are consumed, not kept).
module fft_mag_buffer #(
    parameter int DATA_WIDTH     = 16,
    parameter int POINTS         = 256,
    parameter int DEBUG_BUS_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          enable,
    input  logic                          fft_datao_valid,
    input  logic [DATA_WIDTH-1:0]         fft_re,
    input  logic [DATA_WIDTH-1:0]         fft_im,
    input  logic                          rd_en,
    output logic [2*DATA_WIDTH-1:0]       rd_data,
    output logic                          rd_valid,
    output logic [$clog2(POINTS):0]       count,
    output logic                          empty,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic                          irq,
    output logic [DEBUG_BUS_SIZE-1:0]     debug
);

    localparam int IDX_W = $clog2(POINTS);
    localparam int CNT_W = IDX_W + 1;
    localparam int MAG_W = 2 * DATA_WIDTH;
`ifdef FFT_HALF_SPECTRUM_EN
    localparam int NBINS = POINTS / 2;
`else
    localparam int NBINS = POINTS;
`endif
    localparam int ADDR_W = $clog2(NBINS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        READY   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [MAG_W-1:0]  mem [NBINS];

    logic accept, drop, wr_en, rd_fire, clear;

    logic                         s1_valid, s1_store, s1_last;
    logic signed [DATA_WIDTH-1:0] s1_re, s1_im;
    logic                         s2_valid, s2_store, s2_last;
    logic [MAG_W-1:0]             s2_rr, s2_ii;
    logic                         s3_valid, s3_store, s3_last;
    logic [MAG_W-1:0]             s3_sum;

    logic signed [MAG_W-1:0] re_ext, im_ext, re_sq, im_sq;

    assign accept  = (state == COLLECT) && enable && fft_datao_valid;
    assign drop    = fft_datao_valid && (state != COLLECT);
    assign wr_en   = s3_valid && s3_store && enable;
    assign rd_fire = (state == READY) && enable && rd_en && !empty;
    assign clear   = (state == IDLE) || !enable;
    assign empty   = (count == '0);
    assign irq     = (state == FLUSH) && enable && s3_valid && s3_last;
    assign debug   = DEBUG_BUS_SIZE'({state, ovf, irq});

    // Squares of a DATA_WIDTH signed value never exceed 2^(2*DATA_WIDTH-2), so the
    // truncated signed product is exact and can be reinterpreted as unsigned.
    assign re_ext = {{DATA_WIDTH{s1_re[DATA_WIDTH-1]}}, s1_re};
    assign im_ext = {{DATA_WIDTH{s1_im[DATA_WIDTH-1]}}, s1_im};
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = COLLECT;
                COLLECT: if (accept && idx == IDX_W'(POINTS - 1)) state_next = FLUSH;
                FLUSH:   if (s3_valid && s3_last) state_next = READY;
                READY:   if (count == '0 || (rd_fire && count == CNT_W'(1))) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Dropping enable kills every in-flight tag so an aborted frame can never write or interrupt.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid <= 1'b0;
            s1_store <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_valid <= 1'b0;
            s2_store <= 1'b0;
            s2_last  <= 1'b0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s3_valid <= 1'b0;
            s3_store <= 1'b0;
            s3_last  <= 1'b0;
            s3_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_re    <= fft_re;
                s1_im    <= fft_im;
                s1_store <= (CNT_W'(idx) < CNT_W'(NBINS));
                s1_last  <= (idx == IDX_W'(POINTS - 1));
            end
            s2_valid <= s1_valid && enable;
            s2_store <= s1_store;
            s2_last  <= s1_last;
            s2_rr    <= re_sq;
            s2_ii    <= im_sq;
            s3_valid <= s2_valid && enable;
            s3_store <= s2_store;
            s3_last  <= s2_last;
            s3_sum   <= s2_rr + s2_ii;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) idx <= idx + IDX_W'(1);
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_en && !rd_fire) begin
                count <= count + CNT_W'(1);
            end else if (rd_fire && !wr_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s3_sum;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) rd_data <= mem[rd_ptr];
        end
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_mag_buffer.sv
// tb_fft_mag_buffer: directed frames against a transaction-level model of fft_mag_buffer.
// Honours FFT_HALF_SPECTRUM_EN so the model stores the same number of bins as the design.
module tb_fft_mag_buffer;

    localparam int DW     = 16;
    localparam int POINTS = 256;
    localparam int DBG    = 4;
    localparam int CW     = $clog2(POINTS) + 1;
`ifdef FFT_HALF_SPECTRUM_EN
    localparam int NBINS = POINTS / 2;
`else
    localparam int NBINS = POINTS;
`endif

    logic            clk = 1'b0;
    logic            rstb;
    logic            enable;
    logic            fft_datao_valid;
    logic [DW-1:0]   fft_re;
    logic [DW-1:0]   fft_im;
    logic            rd_en;
    logic [2*DW-1:0] rd_data;
    logic            rd_valid;
    logic [CW-1:0]   count;
    logic            empty;
    logic            ovf;
    logic            ovf_clr;
    logic            irq;
    logic [DBG-1:0]  debug;

    fft_mag_buffer #(
        .DATA_WIDTH(DW),
        .POINTS(POINTS),
        .DEBUG_BUS_SIZE(DBG)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .enable(enable),
        .fft_datao_valid(fft_datao_valid),
        .fft_re(fft_re),
        .fft_im(fft_im),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .count(count),
        .empty(empty),
        .ovf(ovf),
        .ovf_clr(ovf_clr),
        .irq(irq),
        .debug(debug)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int irq_total = 0;
    int irq_cyc = -1;
    logic [31:0] got [$];

    typedef struct {
        int          born;
        logic [31:0] mag;
        bit          store;
        bit          last;
    } item_t;

    // Model: phase of the frame, unread magnitudes in order, bins in flight with their strobe cycle.
    logic [1:0]  m_phase;
    int          m_idx;
    logic [31:0] m_buf [$];
    item_t       m_pipe [$];
    logic        m_ovf;
    logic        m_rd_valid;
    logic [31:0] m_rd_data;
    logic        e_irq;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase    = 2'd0;
        m_idx      = 0;
        m_buf.delete();
        m_pipe.delete();
        m_ovf      = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
    endtask

    task automatic compare_outputs(input logic exp_irq);
        check_output("count", 64'(count), 64'(m_buf.size()));
        check_output("empty", 64'(empty), 64'(m_buf.size() == 0));
        check_output("ovf", 64'(ovf), 64'(m_ovf));
        check_output("irq", 64'(irq), 64'(exp_irq));
        check_output("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        check_output("rd_data", 64'(rd_data), 64'(m_rd_data));
        check_output("debug", 64'(debug), 64'({m_phase, m_ovf, exp_irq}));
    endtask

    task automatic model_advance();
        logic [1:0] p;
        logic [1:0] np;
        item_t      it;
        int         sre;
        int         sim;
        longint     mag64;
        p  = m_phase;
        np = m_phase;
        if (fft_datao_valid && p != 2'd1) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_rd_valid = 1'b0;
        if (p == 2'd3 && enable && rd_en && m_buf.size() > 0) begin
            m_rd_valid = 1'b1;
            m_rd_data  = m_buf.pop_front();
        end
        if (m_pipe.size() > 0 && m_pipe[0].born + 3 == cyc) begin
            it = m_pipe.pop_front();
            if (enable && it.store) m_buf.push_back(it.mag);
            if (enable && it.last && p == 2'd2) np = 2'd3;
        end
        if (p == 2'd1 && enable && fft_datao_valid) begin
            sre      = $signed(fft_re);
            sim      = $signed(fft_im);
            mag64    = longint'(sre) * sre + longint'(sim) * sim;
            it.born  = cyc;
            it.mag   = mag64[31:0];
            it.store = (m_idx < NBINS);
            it.last  = (m_idx == POINTS - 1);
            m_pipe.push_back(it);
            if (it.last) np = 2'd2;
            m_idx = (m_idx + 1) % POINTS;
        end
        if (p == 2'd3 && enable && m_buf.size() == 0) np = 2'd0;
        if (p == 2'd0) begin
            m_buf.delete();
            m_idx = 0;
            if (enable) np = 2'd1;
        end
        if (!enable) begin
            np = 2'd0;
            m_pipe.delete();
            m_buf.delete();
            m_idx = 0;
        end
        m_phase = np;
    endtask

    // Every cycle: outputs against the model, then the model consumes this cycle's inputs.
    always @(negedge clk) begin
        if (!rstb) begin
            model_reset();
            compare_outputs(1'b0);
        end else begin
            e_irq = (m_phase == 2'd2) && enable && (m_pipe.size() > 0) &&
                    (m_pipe[0].born + 3 == cyc) && m_pipe[0].last;
            compare_outputs(e_irq);
            if (irq) begin
                irq_total++;
                irq_cyc = cyc;
            end
            if (rd_valid) got.push_back(rd_data);
            model_advance();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input int re, input int im, input logic rd, input logic clr);
        fft_datao_valid = v;
        fft_re          = re[DW-1:0];
        fft_im          = im[DW-1:0];
        rd_en           = rd;
        ovf_clr         = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int i;
        i = 0;
        while (debug[3:2] != s && i < budget) begin
            tick();
            i++;
        end
        if (debug[3:2] != s) check_output("wait_state", 64'(debug[3:2]), 64'(s));
    endtask

    task automatic stream_frame(input int pattern, input int n, output int last_cyc);
        int re;
        int im;
        for (int i = 0; i < n; i++) begin
            case (pattern)
                0: begin re = i; im = 0; end
                1: begin
                    if (i == 0) begin re = -32768; im = -32768; end
                    else if (i == 1) begin re = 32767; im = 0; end
                    else begin re = i; im = -i; end
                end
                default: begin re = (i * 37) % 2000 - 1000; im = 500 - (i * 13) % 1000; end
            endcase
            last_cyc = cyc;
            apply_stimulus(1'b1, re, im, 1'b0, 1'b0);
        end
        fft_datao_valid = 1'b0;
    endtask

    task automatic wait_irq(input int budget, output int seen_cyc);
        int start;
        start    = irq_total;
        seen_cyc = -1;
        for (int i = 0; i < budget && irq_total == start; i++) tick();
        if (irq_total == start) check_output("irq_timeout", 64'(0), 64'(1));
        else seen_cyc = irq_cyc;
    endtask

    task automatic read_all(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int last_c;
        int irq_c;
        int irq_before;

        rstb            = 1'b0;
        enable          = 1'b0;
        fft_datao_valid = 1'b0;
        fft_re          = '0;
        fft_im          = '0;
        rd_en           = 1'b0;
        ovf_clr         = 1'b0;
        tick(); tick(); tick();
        check_output("reset_count", 64'(count), 64'(0));
        check_output("reset_empty", 64'(empty), 64'(1));
        check_output("reset_debug", 64'(debug), 64'(0));
        rstb = 1'b1;
        tick();

        $display("[TB] full frame, re=idx");
        enable = 1'b1;
        wait_state(2'd1, 5);
        apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
        rd_en = 1'b0;
        check_output("rd_in_collect", 64'(rd_valid), 64'(0));
        stream_frame(0, POINTS, last_c);
        irq_before = irq_total;
        wait_irq(16, irq_c);
        check_output("irq_latency", 64'(irq_c - last_c), 64'(3));
        check_output("frame_count", 64'(count), 64'(NBINS));
        check_output("ready_state", 64'(debug[3:2]), 64'(3));

        $display("[TB] strobes during READY");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 7, 7, 1'b0, 1'b0);
        fft_datao_valid = 1'b0;
        check_output("ovf_set", 64'(ovf), 64'(1));
        check_output("ovf_count_kept", 64'(count), 64'(NBINS));
        apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1);
        check_output("ovf_cleared", 64'(ovf), 64'(0));
        apply_stimulus(1'b1, 5, 5, 1'b0, 1'b1);
        check_output("ovf_set_wins", 64'(ovf), 64'(1));
        apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1);
        ovf_clr = 1'b0;

        got.delete();
        read_all(NBINS);
        check_output("drained_count", 64'(count), 64'(0));
        check_output("drained_empty", 64'(empty), 64'(1));
        check_output("idle_after_read", 64'(debug[3:2]), 64'(0));
        idle(1);
        check_output("irq_single_pulse", 64'(irq_total - irq_before), 64'(1));
        check_output("read_total", 64'(got.size()), 64'(NBINS));
        check_output("bin3", 64'(got[3]), 64'(9));
        check_output("bin_last", 64'(got[NBINS-1]), 64'((NBINS - 1) * (NBINS - 1)));

        $display("[TB] extreme values");
        wait_state(2'd1, 5);
        stream_frame(1, POINTS, last_c);
        wait_irq(16, irq_c);
        got.delete();
        read_all(NBINS);
        idle(1);
        check_output("most_negative", 64'(got[0]), 64'(32'h8000_0000));
        check_output("max_positive", 64'(got[1]), 64'(32'h3FFF_0001));
        check_output("bin2_mixed", 64'(got[2]), 64'(8));

        $display("[TB] abort after 100 strobes");
        wait_state(2'd1, 5);
        stream_frame(2, 100, last_c);
        irq_before = irq_total;
        enable = 1'b0;
        tick();
        check_output("abort_idle", 64'(debug[3:2]), 64'(0));
        check_output("abort_count", 64'(count), 64'(0));
        idle(6);
        check_output("abort_no_irq", 64'(irq_total), 64'(irq_before));
        enable = 1'b1;
        wait_state(2'd1, 5);
        stream_frame(2, POINTS, last_c);
        wait_irq(16, irq_c);
        check_output("rearm_irq_latency", 64'(irq_c - last_c), 64'(3));
        got.delete();
        read_all(NBINS);
        idle(1);
        check_output("rearm_read_total", 64'(got.size()), 64'(NBINS));

        $display("[TB] reset in READY");
        wait_state(2'd1, 5);
        stream_frame(0, POINTS, last_c);
        wait_irq(16, irq_c);
        read_all(10);
        rstb = 1'b0;
        #1;
        check_output("rst_count", 64'(count), 64'(0));
        check_output("rst_empty", 64'(empty), 64'(1));
        check_output("rst_rd_data", 64'(rd_data), 64'(0));
        check_output("rst_rd_valid", 64'(rd_valid), 64'(0));
        check_output("rst_ovf", 64'(ovf), 64'(0));
        check_output("rst_irq", 64'(irq), 64'(0));
        check_output("rst_debug", 64'(debug), 64'(0));
        tick(); tick();
        rstb = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_mag_buffer.md
# fft_mag_buffer

Downstream stage of the FFT controller: consumes the FFT core's output bin stream (one complex bin per `fft_datao_valid` strobe) and computes the squared magnitude of each bin. Stores one frame of magnitudes in a single-port-write/single-port-read buffer and raises an interrupt to the M3 when the frame is complete. The M3 drains the frame through a simple read strobe interface. The block then re-arms for the next frame.

## Interface
- `DATA_WIDTH`, 16, width of signed FFT real/imag outputs
- `POINTS`, 256, FFT length (power of two, ≥ 8)
- `DEBUG_BUS_SIZE`, 4, width of debug bus (≥ 4)
- `clk`  input  1  clock
- `rstb`  input  1  reset, asynchronous, active-low
- `enable`  input  1  block enable; low aborts any frame in progress
- `fft_datao_valid`  input  1  FFT output bin valid strobe
- `fft_re`  input  DATA_WIDTH  signed real part, valid with strobe
- `fft_im`  input  DATA_WIDTH  signed imaginary part, valid with strobe
- `rd_en`  input  1  M3 read request (one bin per cycle)
- `rd_data`  output  2*DATA_WIDTH  unsigned magnitude² of the bin read
- `rd_valid`  output  1  `rd_data` valid
- `count`  output  $clog2(POINTS)+1  bins currently stored and unread
- `empty`  output  1  `count == 0`
- `ovf`  output  1  sticky: an input strobe was dropped
- `ovf_clr`  input  1  clears `ovf`
- `irq`  output  1  one-cycle pulse: frame complete, buffer readable
- `debug`  output  DEBUG_BUS_SIZE  `{zeros, state[1:0], ovf, irq}`

## Operation
- NBINS = POINTS/2 with `FFT_HALF_SPECTRUM_EN`, else POINTS.
- Datapath: 3-stage pipeline.
  - S1 registers `re`/`im`.
  - S2 registers `re*re` and `im*im`, each unsigned 2*DATA_WIDTH.
  - S3 registers the sum.
- Sum rule: maximum is 2^(2*DATA_WIDTH-1), so the sum is exact in 2*DATA_WIDTH bits. No saturation and no truncation.
- Tags: each accepted strobe carries `store` (idx < NBINS) and `last` (idx == POINTS-1) down the pipeline.
- Input index counter `idx` runs 0..POINTS-1 and increments per accepted strobe.
- FSM states: IDLE=0, COLLECT=1, FLUSH=2, READY=3.
  - IDLE: clear `idx`, write pointer, read pointer and `count`. Go to COLLECT when `enable`=1.
  - COLLECT: accept strobes. The strobe with idx==POINTS-1 is accepted, then go to FLUSH.
  - FLUSH: no strobes accepted. When the `last` tag leaves S3: pulse `irq` and go to READY.
  - READY: reads allowed. When `count` reaches 0 after the final read, go to IDLE.
- Write: at S3 output with `store`=1, write to `mem[wr_ptr]`, then increment `wr_ptr` and `count`.
- Read: `rd_en` with `empty`=0 in READY reads `mem[rd_ptr]`, increments `rd_ptr` and decrements `count`.
- Ignored reads: `rd_en` while `empty`=1, or in any state other than READY, has no effect and `rd_valid` stays 0.
- Dropped strobes: a strobe in IDLE, FLUSH or READY is dropped and sets `ovf`. `ovf_clr` clears `ovf`; a simultaneous set wins.
- `enable` falling in COLLECT, FLUSH or READY: go to IDLE next cycle, flush the pipeline tags, no `irq`. Stored data is discarded because the pointers are cleared.
- Pointers never wrap within a frame: at most NBINS writes per frame.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `count`=0, `empty`=1, `ovf`=0, `irq`=0, state=IDLE, all pipeline valids=0.
- Input to write latency: strobe at cycle N is written at the edge ending cycle N+3. `count` reflects it in cycle N+4.
- `irq`: asserted in the cycle the `last` tag is in S3 (N+3 for the last strobe), for one cycle. State is READY from N+4.
- Read latency: `rd_en` in cycle M gives `rd_data`/`rd_valid` in cycle M+1. Back-to-back reads return one bin per cycle.
- `count` and `empty` update the cycle after the read.
- The final read (count 1 to 0) moves the FSM to IDLE the cycle after. COLLECT follows one cycle later if `enable`=1.
- Strobes may arrive every cycle. No backpressure is provided to the FFT core.

## Configuration
- `FFT_HALF_SPECTRUM_EN` defined: NBINS = POINTS/2. Bins POINTS/2..POINTS-1 are consumed but not stored. `irq` still waits for idx POINTS-1.
- `FFT_HALF_SPECTRUM_EN` undefined: NBINS = POINTS, and all bins are stored.

## Test plan
- Full frame, macro undefined: 256 strobes with re=idx, im=0 → `irq` 3 cycles after the last strobe, `count`=256. Reads return idx² in order, and `empty`=1 after read 256.
- Extremes: re=-32768, im=-32768 → `rd_data`=0x80000000. re=32767, im=0 → 0x3FFF0001.
- Half spectrum, macro defined: 256 strobes → `count`=128 and `irq` timing identical to the full-frame case.
- Overflow: 5 strobes during READY → `ovf`=1 and `count` unchanged. `ovf_clr` together with a new dropped strobe → `ovf` stays 1.
- Abort: `enable`=0 after 100 strobes → IDLE next cycle, no `irq`, `count`=0. Re-enable plus 256 strobes → normal frame.
- Reads on empty plus reset: `rd_en` in COLLECT → `rd_valid`=0. Asserting `rstb`=0 mid-READY → all outputs at reset values immediately.
